// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle MIPS control unit.
// Sequences fetch/decode/execute/memory/writeback, handshakes memory through
// memReq/memAck with a bounded wait, and latches a sticky fault on an illegal
// opcode or an acknowledge timeout.
module multicycle_control_fsm #(
    parameter int ACK_TIMEOUT   = 16,
    parameter bit ENABLE_BRANCH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       memAck,
    output logic       memReq,
    output logic       memWe,
    output logic       iorD,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       branchNe,
    output logic [1:0] pcSource,
    output logic       regWrite,
    output logic       regDest,
    output logic       memToReg,
    output logic       signExtend,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       aluFunctSrc,
    output logic [5:0] aluFunct,
    output logic [4:0] aluShamt,
    output logic       instrRetired,
    output logic       fault,
    output logic [1:0] faultCode
);

    // A zero timeout disables the check; keep the counter at least one bit wide.
    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH      = 4'd1,
        S_DECODE     = 4'd2,
        S_EXEC_R     = 4'd3,
        S_EXEC_I     = 4'd4,
        S_MEM_ADDR   = 4'd5,
        S_MEM_ACCESS = 4'd6,
        S_WB_ALU     = 4'd7,
        S_WB_MEM     = 4'd8,
        S_BRANCH     = 4'd9,
        S_JUMP       = 4'd10,
        S_FAULT      = 4'd11
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [5:0]      r_op;
    logic [5:0]      w_op_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [1:0]      r_fault_code;
    logic [1:0]      w_fc_next;
    logic            w_timeout;

    // Successor of DECODE for a given opcode; anything unlisted is illegal.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t s;
        if (op == 6'b000000) begin
            s = S_EXEC_R;
        end else if (op[5:3] == 3'b001) begin
            s = S_EXEC_I;
        end else if ((op == 6'b100011) || (op == 6'b101011)) begin
            s = S_MEM_ADDR;
        end else if (ENABLE_BRANCH && ((op == 6'b000100) || (op == 6'b000101))) begin
            s = S_BRANCH;
        end else if (ENABLE_BRANCH && (op == 6'b000010)) begin
            s = S_JUMP;
        end else begin
            s = S_FAULT;
        end
        return s;
    endfunction

    // The wait limit is reached only when the check is enabled.
    assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == LIMIT);

    // State, latched opcode, wait counter and fault code registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= 6'd0;
            r_cnt        <= {CW{1'b0}};
            r_fault_code <= 2'b00;
        end else begin
            r_state      <= w_next;
            r_op         <= w_op_next;
            r_cnt        <= w_cnt_next;
            r_fault_code <= w_fc_next;
        end
    end

    // Next-state logic; the counter only survives while a request keeps waiting.
    always_comb begin
        w_next     = r_state;
        w_op_next  = r_op;
        w_cnt_next = {CW{1'b0}};
        w_fc_next  = r_fault_code;
        case (r_state)
            S_IDLE:     w_next = S_FETCH;
            S_FETCH: begin
                if (memAck) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next    = S_FAULT;
                    w_fc_next = 2'b10;
                end else begin
                    w_next     = S_FETCH;
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_DECODE: begin
                w_next    = decode_next(opcode);
                w_op_next = opcode;
                if (w_next == S_FAULT) begin
                    w_fc_next = 2'b01;
                end else begin
                    w_fc_next = r_fault_code;
                end
            end
            S_EXEC_R:   w_next = S_WB_ALU;
            S_EXEC_I:   w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = S_MEM_ACCESS;
            S_MEM_ACCESS: begin
                if (memAck) begin
                    w_next = r_op[3] ? S_FETCH : S_WB_MEM;
                end else if (w_timeout) begin
                    w_next    = S_FAULT;
                    w_fc_next = 2'b10;
                end else begin
                    w_next     = S_MEM_ACCESS;
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_WB_ALU:   w_next = S_FETCH;
            S_WB_MEM:   w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_FAULT:    w_next = S_FAULT;
            default: begin
                w_next    = S_FAULT;
                w_fc_next = 2'b01;
            end
        endcase
    end

    // Moore control decode; FETCH writes and the sw retire pulse follow memAck.
    always_comb begin
        memReq       = 1'b0;
        memWe        = 1'b0;
        iorD         = 1'b0;
        irWrite      = 1'b0;
        pcWrite      = 1'b0;
        pcWriteCond  = 1'b0;
        branchNe     = 1'b0;
        pcSource     = 2'b00;
        regWrite     = 1'b0;
        regDest      = 1'b0;
        memToReg     = 1'b0;
        signExtend   = 1'b0;
        aluSrcA      = 1'b0;
        aluSrcB      = 2'b00;
        aluFunctSrc  = 1'b0;
        aluFunct     = 6'b000000;
        aluShamt     = 5'd0;
        instrRetired = 1'b0;
        fault        = 1'b0;
        faultCode    = 2'b00;
        case (r_state)
            S_IDLE: begin
                memReq = 1'b0;
            end
            S_FETCH: begin
                memReq      = 1'b1;
                aluSrcB     = 2'b01;
                aluFunctSrc = 1'b1;
                aluFunct    = 6'b100001;
                irWrite     = memAck;
                pcWrite     = memAck;
            end
            S_DECODE: begin
                aluSrcB     = 2'b11;
                signExtend  = 1'b1;
                aluFunctSrc = 1'b1;
                aluFunct    = 6'b100001;
            end
            S_EXEC_R: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b00;
            end
            S_EXEC_I: begin
                aluSrcA     = 1'b1;
                aluSrcB     = 2'b10;
                aluFunctSrc = 1'b1;
                signExtend  = ~r_op[2];
                if (r_op == 6'b001111) begin
                    aluFunct = 6'b000000;
                    aluShamt = 5'd16;
                end else begin
                    aluFunct = {2'b10, ~r_op[2] & r_op[1], r_op[2:0]};
                end
            end
            S_MEM_ADDR: begin
                aluSrcA     = 1'b1;
                aluSrcB     = 2'b10;
                signExtend  = 1'b1;
                aluFunctSrc = 1'b1;
                aluFunct    = 6'b100001;
            end
            S_MEM_ACCESS: begin
                memReq       = 1'b1;
                iorD         = 1'b1;
                memWe        = r_op[3];
                instrRetired = memAck & r_op[3];
            end
            S_WB_ALU: begin
                regWrite     = 1'b1;
                regDest      = (r_op == 6'b000000);
                instrRetired = 1'b1;
            end
            S_WB_MEM: begin
                regWrite     = 1'b1;
                memToReg     = 1'b1;
                instrRetired = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA      = 1'b1;
                aluFunctSrc  = 1'b1;
                aluFunct     = 6'b100011;
                pcWriteCond  = 1'b1;
                branchNe     = r_op[0];
                pcSource     = 2'b01;
                instrRetired = 1'b1;
            end
            S_JUMP: begin
                pcWrite      = 1'b1;
                pcSource     = 2'b10;
                instrRetired = 1'b1;
            end
            S_FAULT: begin
                fault     = 1'b1;
                faultCode = r_fault_code;
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

endmodule
